sram_arbiter: RTL and testbench

Two-requester arbiter and timing sequencer for the 16-bit asynchronous board SRAM (20-bit word address).
- Port A is the video frame reader: read-only, full-word.
- Port B is the general read/write master: byte enables supported.
- Sits between the video pipeline / CPU-side bridge and the SRAM_* pins. Owns all SRAM control strobes and the DQ tristate.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the board SRAM arbiter.
package sram_arb_pkg;

   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 16;

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;
   typedef enum logic {OWN_A, OWN_B} owner_t;

   // Counter only has to reach ACCESS_CYCLES-1; never narrower than one bit.
   function automatic int acc_cnt_w(input int cycles);
      return (cycles > 2) ? $clog2(cycles) : 1;
   endfunction

   localparam int DEFAULT_ACCESS_CYCLES = 2;
   localparam int DEFAULT_ACC_CNT_W     = acc_cnt_w(DEFAULT_ACCESS_CYCLES);

endpackage

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for the asynchronous board SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed A-over-B priority.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
   parameter int ADDR_W        = SRAM_ADDR_W,
   parameter int DATA_W        = SRAM_DATA_W
) (
   input  logic              clk_0,
   input  logic              reset,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_gnt,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rvalid,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic [1:0]        b_be,
   output logic              b_gnt,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_rvalid,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N
);

   localparam int CNT_W = acc_cnt_w(ACCESS_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_WE_OFF = CNT_W'(ACCESS_CYCLES - 2);
   localparam int LO_W = DATA_W / 2;
   localparam int HI_W = DATA_W - LO_W;

   state_t              state_reg;
   owner_t              owner_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [1:0]          be_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic                drive_en_reg;
   logic [DATA_W-1:0]   rd_mask;
   logic                idle;
   logic                pick_b;

   assign idle = (state_reg == IDLE) && !reset;

`ifdef SRAM_ARB_RR_EN
   owner_t rr_reg;
   assign pick_b = b_req && (!a_req || (rr_reg == OWN_B));
`else
   assign pick_b = b_req && !a_req;
`endif

   assign a_gnt = idle && a_req && !pick_b;
   assign b_gnt = idle && pick_b;

   // Disabled byte lanes of a B read are returned as zero.
   assign rd_mask = {{HI_W{be_reg[1]}}, {LO_W{be_reg[0]}}};

   assign SRAM_DQ = drive_en_reg ? wdata_reg : {DATA_W{1'bz}};

   always_ff @(posedge clk_0) begin
      if (reset) begin
         state_reg    <= IDLE;
         owner_reg    <= OWN_A;
         cnt_reg      <= '0;
         be_reg       <= 2'b11;
         wdata_reg    <= '0;
         drive_en_reg <= 1'b0;
         SRAM_ADDR    <= '0;
         SRAM_CE_N    <= 1'b1;
         SRAM_OE_N    <= 1'b1;
         SRAM_WE_N    <= 1'b1;
         SRAM_UB_N    <= 1'b1;
         SRAM_LB_N    <= 1'b1;
         a_rdata      <= '0;
         b_rdata      <= '0;
         a_rvalid     <= 1'b0;
         b_rvalid     <= 1'b0;
`ifdef SRAM_ARB_RR_EN
         rr_reg       <= OWN_A;
`endif
      end else begin
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (a_gnt || b_gnt) begin
                  owner_reg <= a_gnt ? OWN_A : OWN_B;
                  be_reg    <= a_gnt ? 2'b11 : b_be;
                  wdata_reg <= b_wdata;
                  SRAM_ADDR <= a_gnt ? a_addr : b_addr;
                  SRAM_CE_N <= 1'b0;
                  SRAM_UB_N <= a_gnt ? 1'b0 : ~b_be[1];
                  SRAM_LB_N <= a_gnt ? 1'b0 : ~b_be[0];
                  cnt_reg   <= '0;
`ifdef SRAM_ARB_RR_EN
                  rr_reg    <= a_gnt ? OWN_B : OWN_A;
`endif
                  if (b_gnt && b_we) begin
                     state_reg    <= WR;
                     SRAM_OE_N    <= 1'b1;
                     SRAM_WE_N    <= 1'b0;
                     drive_en_reg <= 1'b1;
                  end else begin
                     state_reg    <= RD;
                     SRAM_OE_N    <= 1'b0;
                     SRAM_WE_N    <= 1'b1;
                     drive_en_reg <= 1'b0;
                  end
               end
            end
            RD, WR: begin
               if (cnt_reg == CNT_LAST) begin
                  // Returning to IDLE gives one dead cycle for DQ turnaround.
                  state_reg    <= IDLE;
                  SRAM_CE_N    <= 1'b1;
                  SRAM_OE_N    <= 1'b1;
                  SRAM_WE_N    <= 1'b1;
                  SRAM_UB_N    <= 1'b1;
                  SRAM_LB_N    <= 1'b1;
                  drive_en_reg <= 1'b0;
                  if (state_reg == RD) begin
                     if (owner_reg == OWN_A) begin
                        a_rdata  <= SRAM_DQ;
                        a_rvalid <= 1'b1;
                     end else begin
                        b_rdata  <= SRAM_DQ & rd_mask;
                        b_rvalid <= 1'b1;
                     end
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
                  // WE_N rises one cycle early so data is held past the write edge.
                  if ((state_reg == WR) && (cnt_reg == CNT_WE_OFF)) begin
                     SRAM_WE_N <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg    <= IDLE;
               SRAM_CE_N    <= 1'b1;
               SRAM_OE_N    <= 1'b1;
               SRAM_WE_N    <= 1'b1;
               SRAM_UB_N    <= 1'b1;
               SRAM_LB_N    <= 1'b1;
               drive_en_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural async SRAM on the pins.
module tb_sram_arbiter;

   localparam int AC = 2;

   logic        clk_0 = 1'b0;
   logic        reset;
   logic        a_req;
   logic [19:0] a_addr;
   logic        a_gnt;
   logic [15:0] a_rdata;
   logic        a_rvalid;
   logic        b_req;
   logic        b_we;
   logic [19:0] b_addr;
   logic [15:0] b_wdata;
   logic [1:0]  b_be;
   logic        b_gnt;
   logic [15:0] b_rdata;
   logic        b_rvalid;
   logic [19:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        ce_n, oe_n, we_n, ub_n, lb_n;

   sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
      .clk_0(clk_0), .reset(reset),
      .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
      .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
      .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
      .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
   );

   always #10 clk_0 = ~clk_0;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t        a_q[$];
   exp_t        b_q[$];
   logic [15:0] sram_mem [0:1023];
   logic [15:0] ref_mem  [0:1023];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          we_low   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // SRAM model: drives the bus on a read, writes enabled lanes while WE_N is low.
   assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr[9:0]] : 16'hzzzz;

   always @(posedge clk_0) cyc <= cyc + 1;

   always @(negedge clk_0) begin : monitor
      exp_t e;
      if (!ce_n && !we_n) begin
         if (!lb_n) sram_mem[sram_addr[9:0]][7:0]  = sram_dq[7:0];
         if (!ub_n) sram_mem[sram_addr[9:0]][15:8] = sram_dq[15:8];
      end
      check_eq("dq_driven_while_oe", {31'b0, dut.drive_en_reg && !oe_n}, 32'd0);
      check_eq("we_low_while_oe", {31'b0, !we_n && !oe_n}, 32'd0);
      if (!we_n) begin
         we_low++;
      end else if (we_low != 0) begin
         check_eq("we_pulse_len", we_low, AC - 1);
         we_low = 0;
      end
      if (a_rvalid) begin
         if (a_q.size() == 0) begin
            check_eq("a_rvalid_spurious", 32'd1, 32'd0);
         end else begin
            e = a_q.pop_front();
            check_eq("a_rdata", a_rdata, e.data);
            check_eq("a_rvalid_cycle", cyc, e.due);
            $display("A read  data=0x%04h cycle=%0d", a_rdata, cyc);
         end
      end
      if (b_rvalid) begin
         if (b_q.size() == 0) begin
            check_eq("b_rvalid_spurious", 32'd1, 32'd0);
         end else begin
            e = b_q.pop_front();
            check_eq("b_rdata", b_rdata, e.data);
            check_eq("b_rvalid_cycle", cyc, e.due);
            $display("B read  data=0x%04h cycle=%0d", b_rdata, cyc);
         end
      end
   end

   task automatic wait_gnt(input bit port_b, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk_0);
         if (port_b ? b_gnt : a_gnt) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         if (port_b) check_eq("b_gnt_timeout", 32'd0, 32'd1);
         else        check_eq("a_gnt_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic b_access(input bit we, input logic [19:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be);
      bit          ok;
      logic [15:0] mask;
      logic [1:0]  nbe;
      mask = {{8{be[1]}}, {8{be[0]}}};
      nbe  = ~be;
      @(posedge clk_0); #1;
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
      wait_gnt(1'b1, ok);
      if (ok) begin
         if (we) begin
            ref_mem[addr[9:0]] = (ref_mem[addr[9:0]] & ~mask) | (wdata & mask);
            $display("B write addr=0x%05h data=0x%04h be=%b cycle=%0d", addr, wdata, be, cyc);
         end else begin
            b_q.push_back('{ref_mem[addr[9:0]] & mask, cyc + AC + 1});
         end
      end
      @(posedge clk_0); #1;
      b_req = 1'b0;
      if (ok) begin
         @(negedge clk_0);
         check_eq("b_ce_n", {31'b0, ce_n}, 32'd0);
         check_eq("b_oe_n", {31'b0, oe_n}, {31'b0, we});
         check_eq("b_ub_lb_n", {30'b0, ub_n, lb_n}, {30'b0, nbe});
         check_eq("b_sram_addr", sram_addr, addr);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 30; n++) begin
         if (a_q.size() == 0 && b_q.size() == 0) break;
         @(negedge clk_0);
      end
      check_eq("a_q_drained", a_q.size(), 32'd0);
      check_eq("b_q_drained", b_q.size(), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk_0); #1;
      reset = 1'b1; a_req = 1'b0; b_req = 1'b0;
      repeat (2) @(posedge clk_0);
      #1 reset = 1'b0;
   endtask

   initial begin
      bit ok;
      bit got;
      bit exp_b;
      int last;
      for (int i = 0; i < 1024; i++) begin
         sram_mem[i] = 16'(i + 16'h0100);
         ref_mem[i]  = 16'(i + 16'h0100);
      end
      reset = 1'b1; a_req = 1'b1; a_addr = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = 2'b11;

      // Reset state, with a request held to show grants stay off.
      repeat (3) @(negedge clk_0);
      check_eq("rst_strobes", {27'b0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1f);
      check_eq("rst_sram_addr", sram_addr, 32'd0);
      check_eq("rst_a_gnt", {31'b0, a_gnt}, 32'd0);
      check_eq("rst_b_gnt", {31'b0, b_gnt}, 32'd0);
      check_eq("rst_rvalids", {30'b0, a_rvalid, b_rvalid}, 32'd0);
      check_eq("rst_a_rdata", a_rdata, 32'd0);
      check_eq("rst_b_rdata", b_rdata, 32'd0);
      check_eq("rst_drive_en", {31'b0, dut.drive_en_reg}, 32'd0);
      @(posedge clk_0); #1;
      a_req = 1'b0; reset = 1'b0;

      // Full-word and byte-lane writes and reads on port B.
      b_access(1'b1, 20'h00010, 16'h1234, 2'b11);
      b_access(1'b0, 20'h00010, 16'h0000, 2'b11);
      b_access(1'b1, 20'h00010, 16'hABCD, 2'b10);
      b_access(1'b0, 20'h00010, 16'h0000, 2'b11);
      b_access(1'b0, 20'h00010, 16'h0000, 2'b01);
      b_access(1'b1, 20'h00010, 16'hFFFF, 2'b00);
      b_access(1'b0, 20'h00010, 16'h0000, 2'b11);
      drain();

      // Port A streaming, request held continuously.
      @(posedge clk_0); #1;
      a_req = 1'b1;
      last  = 0;
      for (int i = 0; i < 8; i++) begin
         a_addr = 20'(i);
         wait_gnt(1'b0, ok);
         if (!ok) break;
         a_q.push_back('{ref_mem[i], cyc + AC + 1});
         if (i > 0) check_eq("a_gnt_spacing", cyc - last, AC + 1);
         last = cyc;
         @(posedge clk_0); #1;
      end
      a_req = 1'b0;
      drain();

      // Both ports requesting continuously for six accesses.
      do_reset();
      a_req = 1'b1; a_addr = 20'h00008;
      b_req = 1'b1; b_we = 1'b0; b_addr = 20'h00010; b_be = 2'b11;
      for (int i = 0; i < 6; i++) begin
         got = 1'b0;
         for (int n = 0; n < 40; n++) begin
            @(negedge clk_0);
            if (a_gnt || b_gnt) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) begin
            check_eq("arb_gnt_timeout", 32'd0, 32'd1);
            break;
         end
`ifdef SRAM_ARB_RR_EN
         exp_b = (i % 2) == 1;
`else
         exp_b = 1'b0;
`endif
         check_eq("arb_winner_is_b", {31'b0, b_gnt}, {31'b0, exp_b});
         check_eq("arb_one_gnt", {31'b0, a_gnt && b_gnt}, 32'd0);
         $display("Arb grant %0d to %s cycle=%0d", i, b_gnt ? "B" : "A", cyc);
         if (b_gnt) b_q.push_back('{ref_mem[10'h010], cyc + AC + 1});
         else       a_q.push_back('{ref_mem[10'h008], cyc + AC + 1});
      end
      @(posedge clk_0); #1;
      a_req = 1'b0; b_req = 1'b0;
      drain();

      // Reset lands in the middle of a write while WE_N is low.
      @(posedge clk_0); #1;
      b_req = 1'b1; b_we = 1'b1; b_addr = 20'h00020; b_wdata = 16'h5555; b_be = 2'b11;
      wait_gnt(1'b1, ok);
      @(posedge clk_0); #1;
      b_req = 1'b0; reset = 1'b1;
      @(negedge clk_0);
      check_eq("midwr_we_n_low", {31'b0, we_n}, 32'd0);
      @(negedge clk_0);
      check_eq("midwr_strobes", {27'b0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1f);
      check_eq("midwr_drive_en", {31'b0, dut.drive_en_reg}, 32'd0);
      check_eq("midwr_b_rvalid", {31'b0, b_rvalid}, 32'd0);
      check_eq("midwr_a_rdata", a_rdata, 32'd0);
      check_eq("midwr_b_rdata", b_rdata, 32'd0);
      $display("Reset mid-write cycle=%0d", cyc);
      @(posedge clk_0); #1;
      reset = 1'b0;

      // Normal operation resumes after the aborted write.
      b_access(1'b0, 20'h00011, 16'h0000, 2'b11);
      drain();
      repeat (4) @(negedge clk_0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
